// File: rtl/echip65_dsm_pkg.sv
// ---------------------------------------------------------------------------
// echip65_dsm_pkg
// Shared definitions for the second-order sigma-delta modulator dsm2_echip65:
// data / integrator / monitor widths, oversampling ratio, full scale, input
// clamp limit, FSM state encoding, monitor select codes and the input clamp
// helper.
// ---------------------------------------------------------------------------
package echip65_dsm_pkg;

   localparam int DATA_W    = 16;      // input sample width
   localparam int INT_W     = 20;      // integrator width
   localparam int PHASE_W   = 8;       // phase counter width
   localparam int OSR       = 256;     // oversampling ratio (clocks per sample)
   localparam int MON_W     = 20;      // digital monitor width
   localparam int FS        = 32768;   // full scale
   localparam int CLAMP_LIM = 24576;   // 0.75 FS input limit

   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OSR - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef enum logic [2:0] {
      MON_ZERO  = 3'd0,
      MON_HOLD  = 3'd1,
      MON_I1    = 3'd2,
      MON_I2    = 3'd3,
      MON_PHASE = 3'd4,
      MON_STATE = 3'd5,
      MON_FLAGS = 3'd6,
      MON_ONES  = 3'd7
   } mon_sel_e;

   // Limit a held sample to +/-CLAMP_LIM.
   function automatic logic signed [DATA_W-1:0] clamp_x(input logic signed [DATA_W-1:0] x);
      logic signed [DATA_W-1:0] r;
      if (x > CLAMP_LIM) begin
         r = DATA_W'(CLAMP_LIM);
      end else if (x < -CLAMP_LIM) begin
         r = DATA_W'(-CLAMP_LIM);
      end else begin
         r = x;
      end
      return r;
   endfunction

endpackage

// File: rtl/dsm2_echip65_if.sv
// ---------------------------------------------------------------------------
// dsm2_echip65_if
// Sample input handshake of the modulator.
//   enable    : modulation request
//   in_data   : signed input sample
//   in_valid  : in_data valid
//   in_ready  : modulator accepts in_data this cycle
// master = sample source, slave = modulator.
// ---------------------------------------------------------------------------
interface dsm2_echip65_if;
   import echip65_dsm_pkg::*;

   logic                     enable;
   logic signed [DATA_W-1:0] in_data;
   logic                     in_valid;
   logic                     in_ready;

   modport master (output enable, output in_data, output in_valid, input in_ready);
   modport slave  (input enable, input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/dsm2_sat_acc.sv
// ---------------------------------------------------------------------------
// dsm2_sat_acc
// Combinational saturating accumulator: sum_o = sat(acc_i + delta_i), clamped
// to the signed W-bit range; ovf_o flags that clamping took place.
//   acc_i   : current accumulator value (signed W)
//   delta_i : increment (signed W)
//   sum_o   : saturated sum (signed W)
//   ovf_o   : 1 when the sum was clamped
// ---------------------------------------------------------------------------
module dsm2_sat_acc #(
   parameter int W = 20
) (
   input  logic signed [W-1:0] acc_i,
   input  logic signed [W-1:0] delta_i,
   output logic signed [W-1:0] sum_o,
   output logic                ovf_o
);

   localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

   logic signed [W:0] full_s;

   // One extra bit of headroom; overflow shows as disagreement of the top two bits.
   always_comb begin
      full_s = {acc_i[W-1], acc_i} + {delta_i[W-1], delta_i};
      if (full_s[W] != full_s[W-1]) begin
         ovf_o = 1'b1;
         if (full_s[W]) begin
            sum_o = MIN_V;
         end else begin
            sum_o = MAX_V;
         end
      end else begin
         ovf_o = 1'b0;
         sum_o = full_s[W-1:0];
      end
   end

endmodule

// File: rtl/dsm2_echip65.sv
// ---------------------------------------------------------------------------
// dsm2_echip65
// Second-order single-bit sigma-delta modulator, OSR 256, zero-order-hold
// interpolation of a 16-bit signed input.
//   clk                 : modulator clock, all state on posedge
//   reset_n             : asynchronous reset, active low
//   dsm_if              : sample handshake (enable, in_data, in_valid, in_ready)
//   out                 : sigma-delta bitstream
//   clip_flag           : sticky, input was clamped to +/-0.75 FS
//   ovf_flag            : sticky, an integrator saturated
//   underrun            : sticky, no sample offered at a frame boundary
//   clear_flags         : synchronous clear of the sticky flags (set wins)
//   digital_monitor_sel : test-point select
//   digital_monitor     : selected internal signal, zero-extended
// ---------------------------------------------------------------------------
module dsm2_echip65
   import echip65_dsm_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   dsm2_echip65_if.slave      dsm_if,
   output logic               out,
   output logic               clip_flag,
   output logic               ovf_flag,
   output logic               underrun,
   input  logic               clear_flags,
   input  logic [2:0]         digital_monitor_sel,
   output logic [MON_W-1:0]   digital_monitor
);

   // Half of the +/-FS feedback; see the delta computation below.
   localparam logic signed [INT_W-1:0] VH_POS = INT_W'(FS / 2);
   localparam logic signed [INT_W-1:0] VH_NEG = -VH_POS;

   state_e                   state_q, state_d;
   logic [PHASE_W-1:0]       phase_q, phase_d;
   logic signed [DATA_W-1:0] hold_q, hold_d;
   logic signed [INT_W-1:0]  i1_q, i1_d;
   logic signed [INT_W-1:0]  i2_q, i2_d;
   logic                     out_q, out_d;
   logic                     in_ready_q, in_ready_d;
   logic                     clip_q, clip_d;
   logic                     ovf_q, ovf_d;
   logic                     udr_q, udr_d;
   logic [MON_W-1:0]         mon_q, mon_d;

   logic signed [DATA_W-1:0] x_s;
   logic signed [DATA_W-1:0] xd_s;
   logic                     clip_hit_s;
   logic signed [INT_W-1:0]  vh_s;
   logic signed [INT_W-1:0]  delta1_s, delta2_s;
   logic signed [INT_W-1:0]  sum1_s, sum2_s;
   logic                     ovf1_s, ovf2_s;
   logic                     set_clip_s, set_ovf_s, set_udr_s;

   // Clamped input and integrator increments. The feedback is always even
   // (+/-FS), so (a - v) >>> 1 equals (a >>> 1) - v/2 exactly.
   always_comb begin
      x_s        = clamp_x(hold_q);
      clip_hit_s = (x_s != hold_q);
      if (out_q) begin
         vh_s = VH_POS;
      end else begin
         vh_s = VH_NEG;
      end
      delta1_s = {{(INT_W-DATA_W+1){x_s[DATA_W-1]}}, x_s[DATA_W-1:1]} - vh_s;
      delta2_s = {i1_q[INT_W-1], i1_q[INT_W-1:1]} - vh_s;
   end

   dsm2_sat_acc #(.W(INT_W)) u_int1 (
      .acc_i   (i1_q),
      .delta_i (delta1_s),
      .sum_o   (sum1_s),
      .ovf_o   (ovf1_s)
   );

   dsm2_sat_acc #(.W(INT_W)) u_int2 (
      .acc_i   (i2_q),
      .delta_i (delta2_s),
      .sum_o   (sum2_s),
      .ovf_o   (ovf2_s)
   );

   // Next-state logic: IDLE/RUN sequencing, sample capture and integration.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      hold_d     = hold_q;
      i1_d       = i1_q;
      i2_d       = i2_q;
      out_d      = out_q;
      set_clip_s = 1'b0;
      set_ovf_s  = 1'b0;
      set_udr_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            phase_d = {PHASE_W{1'b0}};
            i1_d    = {INT_W{1'b0}};
            i2_d    = {INT_W{1'b0}};
            out_d   = ~out_q;
            if (dsm_if.enable && dsm_if.in_valid) begin
               state_d = ST_RUN;
               hold_d  = dsm_if.in_data;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            phase_d = phase_q + 8'd1;
            if (phase_q == PHASE_LAST) begin
               if (dsm_if.in_valid) begin
                  hold_d = dsm_if.in_data;
               end else begin
                  hold_d = hold_q;
               end
               if (!dsm_if.enable) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_RUN;
                  set_udr_s = ~dsm_if.in_valid;
               end
            end else begin
               state_d = ST_RUN;
            end
            // Leaving RUN lands directly in the IDLE condition.
            if (state_d == ST_IDLE) begin
               phase_d = {PHASE_W{1'b0}};
               i1_d    = {INT_W{1'b0}};
               i2_d    = {INT_W{1'b0}};
               out_d   = ~out_q;
            end else begin
               i1_d       = sum1_s;
               i2_d       = sum2_s;
               out_d      = ~sum2_s[INT_W-1];
               set_clip_s = clip_hit_s;
               set_ovf_s  = ovf1_s | ovf2_s;
            end
         end
         default: begin
            state_d = ST_IDLE;
            phase_d = {PHASE_W{1'b0}};
            i1_d    = {INT_W{1'b0}};
            i2_d    = {INT_W{1'b0}};
            out_d   = 1'b0;
         end
      endcase
      in_ready_d = (state_d == ST_IDLE) || (phase_d == PHASE_LAST);
   end

   // Sticky flags: a set in the same cycle as a clear keeps the flag set.
   always_comb begin
      clip_d = (clip_q & ~clear_flags) | set_clip_s;
      ovf_d  = (ovf_q  & ~clear_flags) | set_ovf_s;
      udr_d  = (udr_q  & ~clear_flags) | set_udr_s;
   end

   // Monitor mux built from next-state values so the registered monitor
   // lines up with the registers it reports.
   always_comb begin
      xd_s = clamp_x(hold_d);
      case (mon_sel_e'(digital_monitor_sel))
         MON_ZERO:  mon_d = {MON_W{1'b0}};
         MON_HOLD:  mon_d = {4'b0000, xd_s};
         MON_I1:    mon_d = i1_d;
         MON_I2:    mon_d = i2_d;
         MON_PHASE: mon_d = {12'b0000_0000_0000, phase_d};
         MON_STATE: mon_d = {18'b00_0000_0000_0000_0000, state_d, out_d};
         MON_FLAGS: mon_d = {17'b0_0000_0000_0000_0000, clip_d, ovf_d, udr_d};
         MON_ONES:  mon_d = {MON_W{1'b1}};
         default:   mon_d = {MON_W{1'b0}};
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         phase_q    <= {PHASE_W{1'b0}};
         hold_q     <= {DATA_W{1'b0}};
         i1_q       <= {INT_W{1'b0}};
         i2_q       <= {INT_W{1'b0}};
         out_q      <= 1'b0;
         in_ready_q <= 1'b0;
         clip_q     <= 1'b0;
         ovf_q      <= 1'b0;
         udr_q      <= 1'b0;
         mon_q      <= {MON_W{1'b0}};
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         hold_q     <= hold_d;
         i1_q       <= i1_d;
         i2_q       <= i2_d;
         out_q      <= out_d;
         in_ready_q <= in_ready_d;
         clip_q     <= clip_d;
         ovf_q      <= ovf_d;
         udr_q      <= udr_d;
         mon_q      <= mon_d;
      end
   end

   assign dsm_if.in_ready = in_ready_q;
   assign out             = out_q;
   assign clip_flag       = clip_q;
   assign ovf_flag        = ovf_q;
   assign underrun        = udr_q;
   assign digital_monitor = mon_q;

endmodule

// File: tb/tb_dsm2_echip65.sv
// ---------------------------------------------------------------------------
// tb_dsm2_echip65
// Directed self-checking bench for dsm2_echip65. Inputs are driven 1 time
// unit after the rising edge, outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_dsm2_echip65;
   import echip65_dsm_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        clear_flags;
   logic [2:0]  sel;
   logic        out_w;
   logic        clip_w;
   logic        ovf_w;
   logic        udr_w;
   logic [19:0] mon_w;

   int n_checks;
   int n_fail;
   int ph;

   dsm2_echip65_if bus ();

   dsm2_echip65 dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .dsm_if              (bus),
      .out                 (out_w),
      .clip_flag           (clip_w),
      .ovf_flag            (ovf_w),
      .underrun            (udr_w),
      .clear_flags         (clear_flags),
      .digital_monitor_sel (sel),
      .digital_monitor     (mon_w)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One 256-clock frame starting at phase 0; offers nx at phase 255 when
   // give is set, pulses clear_flags at phase clr_ph, returns ones count.
   task automatic run_frame(input logic signed [15:0] nx, input bit give,
                            input int clr_ph, output int ones);
      bit ready_bad;
      ready_bad = 1'b0;
      ones = 0;
      for (int k = 0; k < 256; k++) begin
         if (bus.in_ready !== (ph == 255)) ready_bad = 1'b1;
         ones += int'(out_w);
         if (ph == 255) begin
            bus.in_valid = give;
            bus.in_data  = nx;
         end
         if (ph == clr_ph) clear_flags = 1'b1;
         tick();
         bus.in_valid = 1'b0;
         clear_flags  = 1'b0;
         ph = (ph + 1) % 256;
      end
      n_checks++;
      if (ready_bad) begin
         n_fail++;
         $display("FAIL frame_in_ready: in_ready not high exactly at phase 255");
      end
   endtask

   task automatic start_run(input logic signed [15:0] x);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_in_ready: got %b want 1", bus.in_ready);
      end
      bus.enable   = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      tick();
      bus.in_valid = 1'b0;
      ph = 0;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL run_phase0_ready: got %b want 0", bus.in_ready);
      end
   endtask

   task automatic test_reset();
      reset_n      = 1'b0;
      bus.enable   = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'sd0;
      clear_flags  = 1'b0;
      sel          = 3'd7;
      repeat (3) tick();
      n_checks++;
      if ({out_w, clip_w, ovf_w, udr_w} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0000", {out_w, clip_w, ovf_w, udr_w});
      end
      n_checks++;
      if (bus.in_ready !== 1'b0 || mon_w !== 20'h00000) begin
         n_fail++;
         $display("FAIL reset_ready_mon: got %b/%h want 0/00000", bus.in_ready, mon_w);
      end
      #2 reset_n = 1'b1;
      tick();
      n_checks++;
      if (out_w !== 1'b1 || bus.in_ready !== 1'b1 || mon_w !== 20'hFFFFF) begin
         n_fail++;
         $display("FAIL first_toggle: got out=%b rdy=%b mon=%h want 1/1/fffff", out_w, bus.in_ready, mon_w);
      end
      tick();
      n_checks++;
      if (out_w !== 1'b0) begin
         n_fail++;
         $display("FAIL second_toggle: got %b want 0", out_w);
      end
   endtask

   task automatic test_idle_monitor();
      sel = 3'd5;
      tick();
      n_checks++;
      if (out_w !== 1'b1 || mon_w !== 20'h00001) begin
         n_fail++;
         $display("FAIL idle_state_mon: got out=%b mon=%h want 1/00001", out_w, mon_w);
      end
      sel = 3'd4;
      tick();
      n_checks++;
      if (out_w !== 1'b0 || mon_w !== 20'h00000) begin
         n_fail++;
         $display("FAIL idle_phase_mon: got out=%b mon=%h want 0/00000", out_w, mon_w);
      end
   endtask

   task automatic test_zero();
      int c;
      start_run(16'sd0);
      run_frame(16'sd0, 1'b1, -1, c);
      run_frame(16'sd0, 1'b1, -1, c);
      run_frame(16'sd16384, 1'b1, -1, c);
      n_checks++;
      if (c < 126 || c > 130) begin
         n_fail++;
         $display("FAIL zero_ones: got %0d want 128+-2", c);
      end
      n_checks++;
      if ({clip_w, ovf_w, udr_w} !== 3'b000) begin
         n_fail++;
         $display("FAIL zero_flags: got %b want 000", {clip_w, ovf_w, udr_w});
      end
   endtask

   task automatic test_pos_neg();
      int c;
      run_frame(16'sd16384, 1'b1, -1, c);
      run_frame(16'sd16384, 1'b1, -1, c);
      run_frame(-16'sd16384, 1'b1, -1, c);
      n_checks++;
      if (c < 190 || c > 194) begin
         n_fail++;
         $display("FAIL pos_ones: got %0d want 192+-2", c);
      end
      run_frame(-16'sd16384, 1'b1, -1, c);
      sel = 3'd1;
      run_frame(-16'sd16384, 1'b1, -1, c);
      n_checks++;
      if (mon_w !== 20'h0C000) begin
         n_fail++;
         $display("FAIL neg_hold_mon: got %h want 0c000", mon_w);
      end
      run_frame(16'sd30000, 1'b1, -1, c);
      n_checks++;
      if (c < 62 || c > 66) begin
         n_fail++;
         $display("FAIL neg_ones: got %0d want 64+-2", c);
      end
   endtask

   task automatic test_clip();
      int c;
      run_frame(16'sd30000, 1'b1, -1, c);
      run_frame(16'sd30000, 1'b1, -1, c);
      n_checks++;
      if (mon_w !== 20'h06000 || clip_w !== 1'b1) begin
         n_fail++;
         $display("FAIL clip_hold: got mon=%h clip=%b want 06000/1", mon_w, clip_w);
      end
      sel = 3'd6;
      run_frame(16'sd0, 1'b1, -1, c);
      n_checks++;
      if (c < 222 || c > 226) begin
         n_fail++;
         $display("FAIL clip_ones: got %0d want 224+-2", c);
      end
      n_checks++;
      if (mon_w !== 20'h00004) begin
         n_fail++;
         $display("FAIL flags_mon: got %h want 00004", mon_w);
      end
      run_frame(16'sd16384, 1'b1, 0, c);
      n_checks++;
      if (clip_w !== 1'b0) begin
         n_fail++;
         $display("FAIL clip_cleared: got %b want 0", clip_w);
      end
   endtask

   task automatic test_underrun();
      int c_prev;
      int c_next;
      int c;
      run_frame(16'sd16384, 1'b1, -1, c);
      run_frame(16'sd16384, 1'b1, -1, c);
      n_checks++;
      if (udr_w !== 1'b0) begin
         n_fail++;
         $display("FAIL udr_before: got %b want 0", udr_w);
      end
      sel = 3'd1;
      run_frame(16'sd0, 1'b0, -1, c_prev);
      n_checks++;
      if (udr_w !== 1'b1 || mon_w !== 20'h04000) begin
         n_fail++;
         $display("FAIL udr_set: got udr=%b hold=%h want 1/04000", udr_w, mon_w);
      end
      run_frame(16'sd16384, 1'b1, -1, c_next);
      n_checks++;
      if (c_next - c_prev > 2 || c_prev - c_next > 2 || c_next < 190 || c_next > 194) begin
         n_fail++;
         $display("FAIL udr_repeat: got %0d after %0d want match+-2 near 192", c_next, c_prev);
      end
      // Clear alone, then clear coinciding with a new underrun.
      run_frame(16'sd16384, 1'b1, 10, c);
      n_checks++;
      if (udr_w !== 1'b0) begin
         n_fail++;
         $display("FAIL udr_clear: got %b want 0", udr_w);
      end
      run_frame(16'sd0, 1'b0, 255, c);
      n_checks++;
      if (udr_w !== 1'b1) begin
         n_fail++;
         $display("FAIL set_beats_clear: got %b want 1", udr_w);
      end
   endtask

   task automatic test_enable_drop();
      logic prev;
      bit   tog_bad;
      sel = 3'd4;
      for (int k = 0; k < 256; k++) begin
         if (ph == 100) bus.enable = 1'b0;
         if (ph == 200) begin
            n_checks++;
            if (mon_w !== 20'd200 || bus.in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL drop_mid_frame: got phase=%0d rdy=%b want 200/0", mon_w, bus.in_ready);
            end
         end
         tick();
         ph = (ph + 1) % 256;
      end
      n_checks++;
      if (bus.in_ready !== 1'b1 || mon_w !== 20'h00000) begin
         n_fail++;
         $display("FAIL drop_idle: got rdy=%b phase=%h want 1/00000", bus.in_ready, mon_w);
      end
      sel = 3'd2;
      tick();
      n_checks++;
      if (mon_w !== 20'h00000) begin
         n_fail++;
         $display("FAIL drop_i1: got %h want 00000", mon_w);
      end
      sel = 3'd3;
      tick();
      n_checks++;
      if (mon_w !== 20'h00000) begin
         n_fail++;
         $display("FAIL drop_i2: got %h want 00000", mon_w);
      end
      sel = 3'd5;
      tick();
      tog_bad = 1'b0;
      for (int k = 0; k < 8; k++) begin
         prev = out_w;
         if (mon_w[1] !== 1'b0) tog_bad = 1'b1;
         tick();
         if (out_w === prev) tog_bad = 1'b1;
      end
      n_checks++;
      if (tog_bad) begin
         n_fail++;
         $display("FAIL drop_toggle: out not toggling in IDLE (last out=%b state=%b) want toggling/0", out_w, mon_w[1]);
      end
   endtask

   task automatic test_reset_mid_run();
      start_run(16'sd16384);
      for (int k = 0; k < 50; k++) begin
         tick();
         ph = ph + 1;
      end
      n_checks++;
      if (udr_w !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_udr: got %b want 1", udr_w);
      end
      sel = 3'd7;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({out_w, clip_w, ovf_w, udr_w, bus.in_ready} !== 5'b00000 || mon_w !== 20'h00000) begin
         n_fail++;
         $display("FAIL mid_run_reset: got %b mon=%h want 00000/00000",
                  {out_w, clip_w, ovf_w, udr_w, bus.in_ready}, mon_w);
      end
      bus.enable = 1'b0;
      sel = 3'd5;
      #1 reset_n = 1'b1;
      tick();
      n_checks++;
      if (out_w !== 1'b1 || mon_w !== 20'h00001 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_idle: got out=%b mon=%h rdy=%b want 1/00001/1", out_w, mon_w, bus.in_ready);
      end
      tick();
      n_checks++;
      if (out_w !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_toggle: got %b want 0", out_w);
      end
   endtask

   initial begin
      clk      = 1'b0;
      n_checks = 0;
      n_fail   = 0;
      ph       = 0;
      test_reset();
      test_idle_monitor();
      test_zero();
      test_pos_neg();
      test_clip();
      test_underrun();
      test_enable_drop();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dsm2_echip65.md
DSM2_ECHIP65 -- requirements
Module: dsm2_echip65

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, ports as listed below.
REQ-002 clk  input  1  high-speed modulator clock; all state on posedge.
REQ-003 reset_n  input  1  asynchronous digital reset, active low.
REQ-004 enable  input  1  request modulation; sampled each clk.
REQ-005 in_data  input  16  signed two's-complement sample, full scale FS = 32768.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out  output  1  single-bit sigma-delta bitstream.
REQ-009 clip_flag  output  1  sticky: input clamped.
REQ-010 ovf_flag  output  1  sticky: integrator saturated.
REQ-011 underrun  output  1  sticky: no sample available at frame boundary.
REQ-012 clear_flags  input  1  synchronous clear of the three sticky flags.
REQ-013 digital_monitor_sel  input  3  internal test-point select.
REQ-014 digital_monitor  output  20  selected internal signal, zero-extended.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and RUN.
REQ-016 IDLE: in_ready=1, integrators held at 0, phase counter held at 0, out toggles every clk starting with 1 (mid-scale pattern).
REQ-017 IDLE->RUN when enable && in_valid; that sample is loaded into the hold register in the same cycle.
REQ-018 RUN: 8-bit phase counter increments every clk and wraps 255->0 (OSR = 256, zero-order-hold interpolation).
REQ-019 RUN: in_ready=1 only when phase==255; a sample accepted there is used from phase 0 onward.
REQ-020 RUN, phase==255, in_valid=0: previous sample repeats; underrun set.
REQ-021 RUN->IDLE only at phase==255 with enable=0; enable deassertion mid-frame completes the frame.
REQ-022 Input clamp: held sample limited to ±24576 (0.75 FS) before use; clip_flag set whenever clamping occurs.
REQ-023 Feedback v = +32768 when out=1, -32768 when out=0.
REQ-024 Integrator 1 (20-bit signed): i1 <= sat(i1 + ((x - v) >>> 1)).
REQ-025 Integrator 2 (20-bit signed): i2 <= sat(i2 + ((i1 - v) >>> 1)), using the pre-update i1.
REQ-026 sat() SHALL clamp to [-2^19, 2^19-1]; ovf_flag set on any clamping.
REQ-027 out <= 1 when the newly computed i2 >= 0, else 0; this is a one-clk latency from the integrator update.
REQ-028 Sticky flags: simultaneous set and clear_flags SHALL leave the flag set.
REQ-029 Monitor codes: 0 zero, 1 held x, 2 i1, 3 i2, 4 phase, 5 {state,out}, 6 flags, 7 all ones.

Reset
REQ-030 reset_n low SHALL force IDLE and set out, phase, i1, i2, hold register and all flags to 0.
REQ-031 Reset applied mid-RUN SHALL take effect immediately, without frame completion.
REQ-032 First toggle after reset release SHALL drive out=1.

Structure
REQ-033 Shared package echip65_dsm_pkg SHALL hold: data and integrator widths, OSR, clamp limit, FS, the state enum and the monitor select codes.
REQ-034 One sub-module, dsm2_sat_acc (parameterised saturating accumulator with overflow output), SHALL be instantiated twice.

Verification
REQ-035 x=0, enable held: after 2 settling frames, ones count per 256-clk frame = 128 ±2; flags all 0.
REQ-036 x=+16384: ones count per frame = 192 ±2; x=-16384: 64 ±2.
REQ-037 x=+30000: clip_flag=1 and ones count = 224 ±2; after clear_flags with x=0 the flag stays 0.
REQ-038 in_valid held low at phase 255: underrun=1, and the next frame's ones count matches the previous frame's ±2.
REQ-039 enable dropped at phase 100: RUN continues to phase 255, then IDLE with i1=i2=0 and out toggling.
REQ-040 reset_n pulsed low at phase 50 of RUN: all outputs 0 in the same cycle; state is IDLE after release.
